// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and helpers for the instruction memory fetch port
package imem_pkg;

    // Port-level operating mode: fetching, waiting for the last response to leave, or loading
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    // Word handed back for a misaligned fetch unless the instance overrides it
    localparam logic [31:0] IMEM_NOP_DEFAULT = 32'h0000_0000;

    // Width of the fetch PC: a byte address carries two extra low bits
    function automatic int imem_pc_width(input int addr_w, input int pc_byte);
        return addr_w + 2 * pc_byte;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - single write / single synchronous read instruction storage array
module imem_ram #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 11,
    parameter string INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write and registered read; the read register only moves on a read so it holds a stalled response
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - instruction memory with a streaming loader and a valid/ready fetch port
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 11,
    parameter int                PC_BYTE   = 1,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(IMEM_NOP_DEFAULT),
    parameter string             INIT_FILE = "",
    localparam int               PC_W      = imem_pc_width(ADDR_W, PC_BYTE)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic [ADDR_W-1:0] i_load_base,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic              o_load_done,
    output logic [ADDR_W:0]   o_load_count,
    input  logic              i_req_valid,
    input  logic [PC_W-1:0]   i_req_pc,
    output logic              o_req_ready,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_instr,
    output logic [PC_W-1:0]   o_rsp_pc,
    output logic              o_rsp_err,
    input  logic              i_flush
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    imem_state_t r_state;
    imem_state_t w_state_nxt;

    logic              w_load_ready;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_load_begin;
    logic              w_load_beat;
    logic              w_load_end;
    logic [ADDR_W-1:0] w_req_idx;
    logic              w_req_misaligned;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;

    logic [ADDR_W-1:0] r_load_addr;
    logic [ADDR_W:0]   r_load_count;
    logic              r_load_done;

    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_from_ram;
    logic [DATA_W-1:0] r_rsp_alt;
    logic [PC_W-1:0]   r_rsp_pc;

    // Split the PC into a word index and an alignment flag; word-addressed PCs are always aligned
    generate
        if (PC_BYTE != 0) begin : g_byte_pc
            assign w_req_idx        = i_req_pc[ADDR_W+1:2];
            assign w_req_misaligned = |i_req_pc[1:0];
        end else begin : g_word_pc
            assign w_req_idx        = i_req_pc[ADDR_W-1:0];
            assign w_req_misaligned = 1'b0;
        end
    endgenerate

    // A load request in RUN always beats a fetch offered in the same cycle
    assign w_load_begin = (r_state == RUN) && i_load_start;
    assign w_load_beat  = (r_state == LOAD) && i_load_valid;
    assign w_load_end   = w_load_beat && i_load_last;
    assign w_accept     = i_req_valid && w_req_ready;
    assign w_ram_re     = w_accept && !w_req_misaligned;

    // Mode register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mode transitions plus the two handshake readies that depend on the mode
    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_req_ready  = 1'b0;
        case (r_state)
            RUN: begin
                w_req_ready = !i_load_start && !i_flush && (!r_rsp_valid || i_rsp_ready);
                if (i_load_start) begin
                    w_state_nxt = r_rsp_valid ? DRAIN : LOAD;
                end
            end
            DRAIN: begin
                if (!r_rsp_valid) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_load_ready = 1'b1;
                if (w_load_end) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Loader address/count; the base is captured at the start request so DRAIN need not hold it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load_addr  <= '0;
            r_load_count <= '0;
            r_load_done  <= 1'b0;
        end else begin
            r_load_done <= w_load_end;
            if (w_load_begin) begin
                r_load_addr  <= i_load_base;
                r_load_count <= '0;
            end else if (w_load_beat) begin
                r_load_addr <= r_load_addr + ADDR_ONE;
                if (r_load_count != COUNT_MAX) begin
                    r_load_count <= r_load_count + COUNT_ONE;
                end
            end
        end
    end

    // Response register; flush beats both a consume and a new accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_from_ram <= 1'b0;
            r_rsp_alt      <= '0;
            r_rsp_pc       <= '0;
        end else begin
            if (i_flush) begin
                r_rsp_valid <= 1'b0;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b1;
            end else if (i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_accept) begin
                r_rsp_pc       <= i_req_pc;
                r_rsp_err      <= w_req_misaligned;
                r_rsp_from_ram <= !w_req_misaligned;
                r_rsp_alt      <= NOP_INSTR;
            end
        end
    end

    imem_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_load_beat),
        .i_waddr (r_load_addr),
        .i_wdata (i_load_data),
        .i_re    (w_ram_re),
        .i_raddr (w_req_idx),
        .o_rdata (w_ram_rdata)
    );

    assign o_load_ready = w_load_ready;
    assign o_load_done  = r_load_done;
    assign o_load_count = r_load_count;
    assign o_req_ready  = w_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_instr  = r_rsp_from_ram ? w_ram_rdata : r_rsp_alt;
    assign o_rsp_pc     = r_rsp_pc;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb/tb_imem_fetch_port.sv - randomized and directed self-checking bench for imem_fetch_port
module tb_imem_fetch_port;

    localparam int          DW    = 32;
    localparam int          AW    = 11;
    localparam int          PW    = 13;
    localparam int          DEPTH = 2048;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          req_valid = 1'b0;
    logic [PW-1:0] req_pc = '0;
    logic          rsp_ready = 1'b0;
    logic          flush = 1'b0;

    logic          o_load_ready;
    logic          o_load_done;
    logic [AW:0]   o_load_count;
    logic          o_req_ready;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_instr;
    logic [PW-1:0] o_rsp_pc;
    logic          o_rsp_err;

    always #5 clk = ~clk;

    imem_fetch_port #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .PC_BYTE   (1),
        .NOP_INSTR (NOP),
        .INIT_FILE ("")
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load_start (load_start),
        .i_load_base  (load_base),
        .i_load_valid (load_valid),
        .i_load_data  (load_data),
        .i_load_last  (load_last),
        .o_load_ready (o_load_ready),
        .o_load_done  (o_load_done),
        .o_load_count (o_load_count),
        .i_req_valid  (req_valid),
        .i_req_pc     (req_pc),
        .o_req_ready  (o_req_ready),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_instr  (o_rsp_instr),
        .o_rsp_pc     (o_rsp_pc),
        .o_rsp_err    (o_rsp_err),
        .i_flush      (flush)
    );

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;
    int done_pulses = 0;
    int deliveries = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: mode 0 = fetching, 1 = waiting for pending response, 2 = loading
    logic [31:0] mem_m [DEPTH];
    bit          known_m [DEPTH];
    int          mode_m = 0;
    bit          rv_m = 1'b0;
    bit          err_m = 1'b0;
    bit          done_m = 1'b0;
    bit          instr_known_m = 1'b1;
    logic [31:0] instr_m = '0;
    logic [12:0] pc_m = '0;
    int          addr_m = 0;
    int          count_m = 0;

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit old_rv;
        int idx;
        if (!rst_n) begin
            mode_m = 0; rv_m = 0; err_m = 0; done_m = 0; instr_m = '0;
            instr_known_m = 1; pc_m = '0; addr_m = 0; count_m = 0;
        end else begin
            old_rv = rv_m;
            acc = (mode_m == 0) && !load_start && !flush && (!old_rv || rsp_ready) && req_valid;
            done_m = (mode_m == 2) && load_valid && load_last;
            if (mode_m == 0) begin
                if (load_start) begin
                    addr_m = int'(load_base);
                    count_m = 0;
                    mode_m = old_rv ? 1 : 2;
                end
            end else if (mode_m == 1) begin
                if (!old_rv) mode_m = 2;
            end else if (load_valid) begin
                mem_m[addr_m] = load_data;
                known_m[addr_m] = 1'b1;
                addr_m = (addr_m + 1) % DEPTH;
                if (count_m < DEPTH) count_m++;
                if (load_last) mode_m = 0;
            end
            if (flush) rv_m = 0;
            else if (acc) rv_m = 1;
            else if (rsp_ready) rv_m = 0;
            if (acc) begin
                pc_m = req_pc;
                if (req_pc[1:0] != 2'b00) begin
                    err_m = 1; instr_m = NOP; instr_known_m = 1;
                end else begin
                    idx = int'(req_pc[12:2]);
                    err_m = 0; instr_m = mem_m[idx]; instr_known_m = known_m[idx];
                end
            end
        end
    end

    // Compare every cycle, half a period away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(o_req_ready),
                32'((mode_m == 0) && !load_start && !flush && (!rv_m || rsp_ready)));
            chk("load_ready", 32'(o_load_ready), 32'(mode_m == 2));
            chk("rsp_valid", 32'(o_rsp_valid), 32'(rv_m));
            chk("load_done", 32'(o_load_done), 32'(done_m));
            chk("load_count", 32'(o_load_count), 32'(count_m));
            if (rv_m) begin
                chk("rsp_pc", 32'(o_rsp_pc), 32'(pc_m));
                chk("rsp_err", 32'(o_rsp_err), 32'(err_m));
                if (instr_known_m) chk("rsp_instr", o_rsp_instr, instr_m);
            end
        end
        if (rst_n && o_load_done) done_pulses++;
        if (rst_n && o_rsp_valid && rsp_ready && !flush) deliveries++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beats(input int n, input logic [31:0] seed, input bit gaps, input int stop_after);
        int budget = 0;
        while (!o_load_ready && budget < 50) begin
            tick();
            budget++;
        end
        chk("load_ready_wait", 32'(o_load_ready), 32'd1);
        if (o_load_ready) begin
            for (int i = 0; i < n; i++) begin
                if (i == stop_after) break;
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        load_valid = 1'b0;
                        tick();
                    end
                end
                load_valid = 1'b1;
                load_data = seed + 32'(i);
                load_last = (i == n - 1);
                tick();
            end
        end
        load_valid = 1'b0;
        load_last = 1'b0;
    endtask

    task automatic fetch_expect(input logic [12:0] pc, input logic [31:0] exp, input string name);
        req_valid = 1'b1;
        req_pc = pc;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        #1;
        chk({name, "_valid"}, 32'(o_rsp_valid), 32'd1);
        chk({name, "_pc"}, 32'(o_rsp_pc), 32'(pc));
        chk({name, "_instr"}, o_rsp_instr, exp);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int w;
        repeat (3) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_instr", o_rsp_instr, 32'd0);
        chk("rst_rsp_pc", 32'(o_rsp_pc), 32'd0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst_load_count", 32'(o_load_count), 32'd0);
        chk("rst_load_done", 32'(o_load_done), 32'd0);
        chk("rst_load_ready", 32'(o_load_ready), 32'd0);
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);

        // Seed words 0..63 with 0x1000_0000 + index
        load_base = '0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_beats(64, 32'h1000_0000, 1'b0, -1);
        tick();
        fetch_expect(13'h010, 32'h1000_0004, "fetch_0x10");

        // Wrapping load at the top of the array
        d0 = done_pulses;
        load_base = 11'h7FE;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_beats(4, 32'hA0A0_0000, 1'b1, -1);
        tick();
        chk("wrap_count", 32'(o_load_count), 32'd4);
        chk("wrap_done_pulses", 32'(done_pulses - d0), 32'd1);
        fetch_expect(13'h1FF8, 32'hA0A0_0000, "wrap_7fe");
        fetch_expect(13'h1FFC, 32'hA0A0_0001, "wrap_7ff");
        fetch_expect(13'h0000, 32'hA0A0_0002, "wrap_000");
        fetch_expect(13'h0004, 32'hA0A0_0003, "wrap_001");
        fetch_expect(13'h0008, 32'h1000_0002, "wrap_002");

        // Back-pressure: response held for three cycles, exactly one delivery
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 13'h020;
        tick();
        d0 = deliveries;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_ready", 32'(o_req_ready), 32'd0);
            chk("stall_pc", 32'(o_rsp_pc), 32'h20);
            chk("stall_instr", o_rsp_instr, 32'h1000_0008);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        chk("stall_deliveries", 32'(deliveries - d0), 32'd1);

        // Load request while a response is pending goes through DRAIN
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 13'h024;
        tick();
        load_base = 11'h040;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_load_ready", 32'(o_load_ready), 32'd0);
            chk("drain_req_ready", 32'(o_req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("drain_after_consume", 32'(o_load_ready), 32'd0);
        tick();
        chk("drain_to_load", 32'(o_load_ready), 32'd1);
        req_valid = 1'b0;
        load_beats(3, 32'hC0C0_0000, 1'b0, -1);
        tick();
        fetch_expect(13'h0100, 32'hC0C0_0000, "drain_load");

        // Misaligned fetch, then flush of the pending response
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 13'h013;
        tick();
        req_valid = 1'b0;
        chk("mis_valid", 32'(o_rsp_valid), 32'd1);
        chk("mis_err", 32'(o_rsp_err), 32'd1);
        chk("mis_instr", o_rsp_instr, NOP);
        chk("mis_pc", 32'(o_rsp_pc), 32'h13);
        flush = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc = 13'h000;
        #1;
        chk("flush_blocks_req", 32'(o_req_ready), 32'd0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_clears", 32'(o_rsp_valid), 32'd0);
        tick();

        // Reset after the second beat of a five-beat load
        d0 = done_pulses;
        load_base = 11'h100;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_beats(5, 32'hD0D0_0000, 1'b0, 2);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_done", 32'(done_pulses - d0), 32'd0);
        chk("rst_mid_load_ready", 32'(o_load_ready), 32'd0);
        fetch_expect(13'h0400, 32'hD0D0_0000, "rst_mid_b1");
        fetch_expect(13'h0404, 32'hD0D0_0001, "rst_mid_b2");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            w = $urandom_range(0, 127);
            req_pc = 13'(w * 4);
            if ($urandom_range(0, 7) == 0) req_pc = req_pc | 13'($urandom_range(1, 3));
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            load_start = ($urandom_range(0, 49) == 0);
            load_base = 11'($urandom_range(0, 127));
            load_valid = $urandom_range(0, 1) == 1;
            load_last = ($urandom_range(0, 7) == 0);
            load_data = $urandom;
            tick();
        end
        req_valid = 1'b0;
        flush = 1'b0;
        load_start = 1'b0;
        rsp_ready = 1'b1;
        load_valid = 1'b1;
        load_last = 1'b1;
        repeat (4) tick();
        load_valid = 1'b0;
        load_last = 1'b0;
        repeat (3) tick();
        chk("end_idle_ready", 32'(o_req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
